edge_interval_counter: RTL and testbench

- Upstream feeder of the shift-register stage in the oversampled receive path.
- Watches the 1-bit oversampled line RxIn, detects transitions, and measures the number of Clk cycles between consecutive edges.
- Each measured interval is presented as a DataIn-width word with a one-cycle valid strobe, so the shift register can hold the last n intervals for symbol-timing decisions.
- Intervals longer than SAMPLES*OSF are treated as a timeout and are not reported.

---
 rtl/edge_interval_counter.sv | 148 ++++++++++++++
 tb/tb_edge_interval_counter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_interval_counter.sv
// -----------------------------------------------------------------------------
// edge_interval_counter
//
// Feeds the shift-register stage of the oversampled receive path. The block
// watches the oversampled serial line, finds its transitions, and measures
// the number of Clk cycles between consecutive edges. Each measured interval
// is presented on DataOut with a one-cycle DataValid strobe. An interval that
// runs to MAX cycles with no edge is a timeout and is not reported as data.
//
// Parameters
//   SAMPLES  symbols per measurement window
//   OSF      oversampling factor (Clk cycles per symbol)
//   MAX      SAMPLES*OSF, longest reportable interval / timeout limit
//   W        output width, $clog2(MAX)+1, so W bits always hold MAX
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   Enable     in   synchronous measurement enable
//   RxIn       in   oversampled serial line, asynchronous to Clk
//   DataOut    out  last measured edge-to-edge interval (1..MAX)
//   DataValid  out  one-cycle pulse when DataOut is updated
//   DataLevel  out  line level during the reported interval
//   Timeout    out  one-cycle pulse when MAX cycles pass with no edge
// -----------------------------------------------------------------------------
module edge_interval_counter #(
  parameter  int SAMPLES = 2,
  parameter  int OSF     = 8,
  localparam int MAX     = SAMPLES * OSF,
  localparam int W       = $clog2(MAX) + 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Enable,
  input  logic         RxIn,
  output logic [W-1:0] DataOut,
  output logic         DataValid,
  output logic         DataLevel,
  output logic         Timeout
);

  localparam logic [W-1:0] MAX_CNT = W'(MAX);
  localparam logic [W-1:0] ONE     = W'(1);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  // Two-flop synchroniser plus one history flop for edge detection.
  logic s1, s2, s3;
  logic rx_edge;

  state_t       state, state_nx;
  logic [W-1:0] cnt, cnt_nx;
  logic [W-1:0] data_out_nx;
  logic         data_level_nx;
  logic         data_valid_nx;
  logic         timeout_nx;

  // The synchroniser runs regardless of Enable so that re-enabling never sees
  // a stale transition left over from while measurement was off.
  // NOTE: every clocked assignment is non-blocking so all flops update from
  // the same pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= RxIn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rx_edge = s2 ^ s3;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      DataOut   <= '0;
      DataValid <= 1'b0;
      DataLevel <= 1'b0;
      Timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      DataOut   <= data_out_nx;
      DataValid <= data_valid_nx;
      DataLevel <= data_level_nx;
      Timeout   <= timeout_nx;
    end
  end

  // NOTE: every output of this block is given a default before any branch,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    data_out_nx   = DataOut;
    data_level_nx = DataLevel;
    data_valid_nx = 1'b0;
    timeout_nx    = 1'b0;

    if (!Enable) begin
      // Measurement off: drop any partial interval, hold the last result.
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_edge) begin
            // First edge only opens an interval; nothing to report yet.
            state_nx = COUNT;
            cnt_nx   = ONE;
          end else begin
            cnt_nx = '0;
          end
        end

        COUNT: begin
          if (rx_edge) begin
            // The edge has priority over the timeout, so an edge landing on
            // cnt == MAX reports MAX rather than timing out.
            data_out_nx   = cnt;
            data_level_nx = s3;
            data_valid_nx = 1'b1;
            cnt_nx        = ONE;
          end else if (cnt == MAX_CNT) begin
            timeout_nx = 1'b1;
            cnt_nx     = '0;
            state_nx   = IDLE;
          end else begin
            cnt_nx = cnt + ONE;
          end
        end

        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_interval_counter.sv
// -----------------------------------------------------------------------------
// tb_edge_interval_counter
//
// Self-checking bench for edge_interval_counter. A behavioural model tracks
// the cycle number of the last detected edge and derives intervals, levels
// and timeouts by plain arithmetic; a compare process checks every DUT output
// against it on every falling clock edge. Directed scenarios add literal
// expectations, followed by randomized line activity.
// -----------------------------------------------------------------------------
module tb_edge_interval_counter;

  localparam int SAMPLES = 2;
  localparam int OSF     = 8;
  localparam int MAX     = SAMPLES * OSF;
  localparam int W       = $clog2(MAX) + 1;

  logic         Clk;
  logic         Reset;
  logic         Enable;
  logic         RxIn;
  logic [W-1:0] DataOut;
  logic         DataValid;
  logic         DataLevel;
  logic         Timeout;

  edge_interval_counter #(
    .SAMPLES (SAMPLES),
    .OSF     (OSF)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Enable    (Enable),
    .RxIn      (RxIn),
    .DataOut   (DataOut),
    .DataValid (DataValid),
    .DataLevel (DataLevel),
    .Timeout   (Timeout)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. hist holds the line samples of the last three edges
  // (bit 0 newest); a transition is seen when the samples taken two and three
  // edges ago differ. Intervals are the difference of edge cycle numbers.
  // ---------------------------------------------------------------------------
  logic [2:0] hist;
  int         cyc = 0;
  int         last_edge;
  bit         active;
  int         m_out;
  bit         m_valid, m_level, m_to;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hist    <= '0;
      active  <= 1'b0;
      last_edge <= 0;
      m_out   <= 0;
      m_valid <= 1'b0;
      m_level <= 1'b0;
      m_to    <= 1'b0;
    end else begin
      automatic int  now = cyc + 1;
      automatic bit  seen = hist[1] != hist[2];
      cyc     <= now;
      hist    <= {hist[1:0], RxIn};
      m_valid <= 1'b0;
      m_to    <= 1'b0;
      if (!Enable) begin
        active <= 1'b0;
      end else if (seen) begin
        if (active) begin
          m_valid <= 1'b1;
          m_out   <= now - last_edge;
          m_level <= hist[2];
        end
        active    <= 1'b1;
        last_edge <= now;
      end else if (active && (now - last_edge) == MAX) begin
        m_to   <= 1'b1;
        active <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process and observation log (sampled on the falling edge).
  // ---------------------------------------------------------------------------
  int outs[$];
  int lvls[$];
  int n_valid, n_to, run_v, max_run;

  always @(negedge Clk) begin
    check("data_out",   int'(DataOut),   m_out);
    check("data_valid", int'(DataValid), int'(m_valid));
    check("data_level", int'(DataLevel), int'(m_level));
    check("timeout",    int'(Timeout),   int'(m_to));
    if (DataValid) begin
      outs.push_back(int'(DataOut));
      lvls.push_back(int'(DataLevel));
      n_valid++;
      run_v++;
      if (run_v > max_run) max_run = run_v;
    end else begin
      run_v = 0;
    end
    if (Timeout) n_to++;
  end

  task automatic clear_mon();
    outs.delete();
    lvls.delete();
    n_valid = 0;
    n_to    = 0;
    run_v   = 0;
    max_run = 0;
  endtask

  // Advance n rising edges, then settle 2 time units past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic toggle_hold(input int n);
    RxIn = ~RxIn;
    step(n);
  endtask

  initial begin
    Reset  = 1'b0;
    Enable = 1'b0;
    RxIn   = 1'b0;
    clear_mon();
    step(1);

    // 1: reset held while the line toggles, then a long idle line.
    for (int i = 0; i < 6; i++) toggle_hold(1);
    check("rst_data_out",   int'(DataOut),   0);
    check("rst_data_valid", int'(DataValid), 0);
    check("rst_data_level", int'(DataLevel), 0);
    check("rst_timeout",    int'(Timeout),   0);
    RxIn   = 1'b0;
    step(1);
    Reset  = 1'b1;
    Enable = 1'b1;
    clear_mon();
    step(40);
    check("idle_valid_cnt",   n_valid, 0);
    check("idle_timeout_cnt", n_to,    0);

    // 2: toggling every 8 cycles; first edge only starts the measurement.
    clear_mon();
    for (int i = 0; i < 6; i++) toggle_hold(8);
    toggle_hold(4);
    check("t8_count", outs.size(), 6);
    foreach (outs[i]) check("t8_interval", outs[i], 8);
    if (lvls.size() >= 2) begin
      check("t8_level0", lvls[0], 1);
      check("t8_level1", lvls[1], 0);
    end
    step(20);

    // 3: runs of 3, 5 and 16 cycles; the 16 run must not time out.
    clear_mon();
    toggle_hold(3);
    toggle_hold(5);
    toggle_hold(16);
    toggle_hold(4);
    check("runs_count", outs.size(), 3);
    if (outs.size() == 3) begin
      check("run_3",  outs[0], 3);
      check("run_5",  outs[1], 5);
      check("run_16", outs[2], 16);
    end
    check("runs_no_timeout", n_to, 0);

    // 4: line held past MAX; one timeout, DataOut keeps its last value.
    clear_mon();
    step(20);
    check("to_count",    n_to,           1);
    check("to_hold_out", int'(DataOut),  16);
    check("to_no_valid", n_valid,        0);
    toggle_hold(4);
    toggle_hold(4);
    check("to_restart_count", outs.size(), 1);
    if (outs.size() == 1) check("to_restart_interval", outs[0], 4);

    // 5: toggling every cycle gives back-to-back strobes of 1.
    step(20);
    clear_mon();
    for (int i = 0; i < 20; i++) toggle_hold(1);
    step(4);
    check("fast_run_len", max_run, 19);
    foreach (outs[i]) check("fast_interval", outs[i], 1);

    // 6: Enable dropped mid-interval, then reset pulsed mid-interval.
    step(20);
    clear_mon();
    toggle_hold(3);
    Enable = 1'b0;
    step(5);
    Enable = 1'b1;
    step(3);
    check("en_no_valid", n_valid, 0);
    toggle_hold(4);
    toggle_hold(3);
    Reset = 1'b0;
    #1;
    check("arst_data_out",   int'(DataOut),   0);
    check("arst_data_valid", int'(DataValid), 0);
    check("arst_data_level", int'(DataLevel), 0);
    check("arst_timeout",    int'(Timeout),   0);
    step(2);
    Reset = 1'b1;
    clear_mon();
    step(10);
    check("arst_no_valid", n_valid, 0);

    // Randomized line activity, occasional enable drops and reset pulses.
    for (int i = 0; i < 400; i++) begin
      Enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) begin
        Reset = 1'b0;
        step(1);
        Reset = 1'b1;
      end
      toggle_hold($urandom_range(1, 20));
    end
    step(MAX + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
